fifo_push_driver: RTL and testbench
===================================

FIFO_PUSH_DRIVER -- requirements
Module: fifo_push_driver

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of wdata and seed.
REQ-002 Parameter CNT_WIDTH, default 16: width of num_words, pushed_cnt and stall_cnt.
REQ-003 Parameter GAP_WIDTH, default 4: width of gap.
REQ-004 Parameter DRAIN_CYCLES, default 10: idle cycles after the last push before done.
REQ-005 wclk  in  1  single clock; all state updates on rising edge.
REQ-006 wrst_n  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  single-cycle request to begin a run; sampled only in IDLE or DONE.
REQ-008 num_words  in  CNT_WIDTH  words in the run; sampled with start.
REQ-009 mode  in  2  data pattern: 00 increment, 01 LFSR, 10 constant, 11 reserved (treated as 00); sampled with start.
REQ-010 seed  in  DATA_WIDTH  first data value; sampled with start.
REQ-011 gap  in  GAP_WIDTH  idle cycles inserted after each accepted push; sampled with start.
REQ-012 wfull  in  1  FIFO full backpressure.
REQ-013 winc  out  1  push strobe to FIFO.
REQ-014 wdata  out  DATA_WIDTH  push data, registered.
REQ-015 busy  out  1  high in PUSH, GAP, DRAIN.
REQ-016 done  out  1  sticky run-complete flag.
REQ-017 pushed_cnt  out  CNT_WIDTH  words accepted in current/last run.
REQ-018 stall_cnt  out  CNT_WIDTH  cycles in PUSH with wfull=1 (see Configuration).

Function
REQ-019 States SHALL be IDLE, PUSH, GAP, DRAIN, DONE.
REQ-020 IDLE/DONE + start, num_words>0 -> PUSH next cycle; done cleared, pushed_cnt and stall_cnt zeroed, wdata loaded with seed.
REQ-021 IDLE/DONE + start, num_words=0 -> DONE next cycle, no push, done=1.
REQ-022 start in PUSH/GAP/DRAIN SHALL be ignored.
REQ-023 winc SHALL equal (state==PUSH) AND NOT wfull, combinational in wfull only.
REQ-024 A push is accepted on a rising wclk with winc=1; wdata SHALL be stable for that whole cycle.
REQ-025 On accept: pushed_cnt+1; wdata advances to next pattern value; next state GAP if gap>0 (counter loaded gap), else PUSH; if pushed_cnt+1==num_words next state DRAIN instead.
REQ-026 GAP counts down gap cycles, then returns to PUSH; winc=0 throughout.
REQ-027 wfull=1 in PUSH: state, wdata, pushed_cnt hold; stall_cnt+1 (saturating at all-ones).
REQ-028 Increment mode: next = wdata+1 modulo 2^DATA_WIDTH (all-ones wraps to 0).
REQ-029 LFSR mode: internal 32-bit Fibonacci LFSR, taps 32,22,2,1, shift left, loaded {zero-extended seed}, zero seed replaced by 1; wdata = low DATA_WIDTH bits, first word = seed (or 1 if seed=0).
REQ-030 Constant mode: wdata = seed for every word.
REQ-031 DRAIN holds winc=0 for exactly DRAIN_CYCLES cycles, then DONE with done=1.
REQ-032 DONE holds done=1, pushed_cnt, stall_cnt until next accepted start or reset.
REQ-033 In IDLE and DONE wdata SHALL be 0 except in the cycle a start is accepted.

Reset
REQ-034 wrst_n low SHALL immediately force IDLE, winc=0, wdata=0, busy=0, done=0, pushed_cnt=0, stall_cnt=0, gap counter=0, LFSR=1.
REQ-035 Reset mid-run SHALL abandon the run with no further pushes; done stays 0.
REQ-036 Deassertion is taken synchronously at the next wclk edge; start on that edge may be accepted.

Configuration
REQ-037 Macro FIFO_DRV_STALL_CNT_EN defined: stall counter implemented per REQ-027.
REQ-038 Macro undefined: stall_cnt port present, tied to 0, no counter logic.

Verification
REQ-039 Reset, start num_words=4 mode=00 seed=8'hFE gap=0 wfull=0 -> winc high 4 consecutive cycles, wdata FE,FF,00,01, done after 10 idle cycles, pushed_cnt=4.
REQ-040 num_words=3 mode=10 seed=8'h5A gap=2 -> pushes 2 cycles apart, all 5A, pushed_cnt=3.
REQ-041 num_words=5 mode=00 seed=0, wfull high 3 cycles after 2nd push -> winc low those 3 cycles, data 00..04 in order without gaps or repeats, stall_cnt=3 (0 with macro undefined).
REQ-042 mode=01 seed=0 num_words=2 -> first wdata 8'h01, second low byte of LFSR after one shift (8'h02), done asserted.
REQ-043 wrst_n pulsed low after 2 of 6 pushes -> winc low asynchronously, busy=0, done=0, pushed_cnt=0; new start runs cleanly.
REQ-044 start with num_words=0 -> done next cycle, no winc; start during busy -> ignored, original run completes.

Source files
------------

// File: rtl/fifo_push_driver.sv
// fifo_push_driver: pushes a run of pattern words (inc/LFSR/const) into a FIFO.
// Define FIFO_DRV_STALL_CNT_EN to count wfull stall cycles on stall_cnt.
module fifo_push_driver #(
  parameter int DATA_WIDTH   = 8,
  parameter int CNT_WIDTH    = 16,
  parameter int GAP_WIDTH    = 4,
  parameter int DRAIN_CYCLES = 10
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  num_words,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic [GAP_WIDTH-1:0]  gap,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  pushed_cnt,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  localparam int DRW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRW-1:0] DRAIN_LOAD = DRW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    PUSH,
    GAP,
    DRAIN,
    DONE
  } state_t;

  state_t                state;
  logic [CNT_WIDTH-1:0]  num_q;
  logic [CNT_WIDTH-1:0]  pushed_q;
  logic [CNT_WIDTH-1:0]  pushed_inc;
  logic [GAP_WIDTH-1:0]  gap_q;
  logic [GAP_WIDTH-1:0]  gap_cnt;
  logic [DRW-1:0]        drain_cnt;
  logic [1:0]            mode_q;
  logic [DATA_WIDTH-1:0] seed_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] next_data;
  logic [31:0]           lfsr;
  logic [31:0]           lfsr_nxt;
  logic [31:0]           lfsr_init;
  logic                  start_ok;

  assign start_ok   = start && (state == IDLE || state == DONE);
  assign pushed_inc = pushed_q + CNT_WIDTH'(1);
  assign winc       = (state == PUSH) && !wfull;
  assign busy       = (state == PUSH) || (state == GAP) ||
                      (state == DRAIN);
  assign wdata      = wdata_q;
  assign pushed_cnt = pushed_q;

  // XNOR Fibonacci form, taps 32,22,2,1
  assign lfsr_nxt  = {lfsr[30:0], ~(lfsr[31] ^ lfsr[21] ^
                                    lfsr[1] ^ lfsr[0])};
  assign lfsr_init = (seed == '0) ? 32'd1 : 32'(seed);

  always_comb begin
    next_data = wdata_q + DATA_WIDTH'(1);
    unique case (1'b1)
      mode_q == 2'b01: next_data = lfsr_nxt[DATA_WIDTH-1:0];
      mode_q == 2'b10: next_data = seed_q;
      default:         ;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state     <= IDLE;
      num_q     <= '0;
      pushed_q  <= '0;
      gap_q     <= '0;
      gap_cnt   <= '0;
      drain_cnt <= '0;
      mode_q    <= '0;
      seed_q    <= '0;
      wdata_q   <= '0;
      lfsr      <= 32'd1;
      done      <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            num_q    <= num_words;
            gap_q    <= gap;
            mode_q   <= mode;
            seed_q   <= seed;
            lfsr     <= lfsr_init;
            pushed_q <= '0;
            if (num_words == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state   <= PUSH;
              done    <= 1'b0;
              wdata_q <= (mode == 2'b01) ?
                         lfsr_init[DATA_WIDTH-1:0] : seed;
            end
          end
        end
        PUSH: begin
          if (!wfull) begin
            pushed_q <= pushed_inc;
            wdata_q  <= next_data;
            if (mode_q == 2'b01) lfsr <= lfsr_nxt;
            if (pushed_inc == num_q) begin
              state     <= DRAIN;
              drain_cnt <= DRAIN_LOAD;
            end else if (gap_q != '0) begin
              state   <= GAP;
              gap_cnt <= gap_q;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_WIDTH'(1)) begin
            state   <= PUSH;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt - GAP_WIDTH'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state   <= DONE;
            done    <= 1'b1;
            wdata_q <= '0;
          end else begin
            drain_cnt <= drain_cnt - DRW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_DRV_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] stall_q;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      stall_q <= '0;
    end else if (start_ok) begin
      stall_q <= '0;
    end else if (state == PUSH && wfull && !(&stall_q)) begin
      stall_q <= stall_q + CNT_WIDTH'(1);
    end
  end

  assign stall_cnt = stall_q;
`else
  logic unused_ok;
  assign unused_ok = start_ok;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_push_driver.sv
// tb_fifo_push_driver: scoreboard bench for fifo_push_driver.
// Expected words are queued at start and popped on every winc.
module tb_fifo_push_driver;

  logic        wclk = 1'b0;
  logic        wrst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_words = '0;
  logic [1:0]  mode = '0;
  logic [7:0]  seed = '0;
  logic [3:0]  gap = '0;
  logic        wfull = 1'b0;
  logic        winc;
  logic [7:0]  wdata;
  logic        busy;
  logic        done;
  logic [15:0] pushed_cnt;
  logic [15:0] stall_cnt;

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          n_push = 0;
  int          done_cyc = 0;
  logic [7:0]  exp_q[$];
  int          push_cyc[$];

  fifo_push_driver dut (
    .wclk       (wclk),
    .wrst_n     (wrst_n),
    .start      (start),
    .num_words  (num_words),
    .mode       (mode),
    .seed       (seed),
    .gap        (gap),
    .wfull      (wfull),
    .winc       (winc),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .pushed_cnt (pushed_cnt),
    .stall_cnt  (stall_cnt)
  );

  always #5 wclk = ~wclk;
  always @(posedge wclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge wclk) begin
    #2;
    if (wrst_n) begin
      if (wfull) chk("winc_full", 32'(winc), 0);
      if (winc) begin
        push_cyc.push_back(cyc);
        n_push++;
        if (exp_q.size() == 0) chk("extra_push", 1, 0);
        else chk("wdata", 32'(wdata), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic go(input int nw, input int md, input int sd,
                    input int gp);
    logic [31:0] l;
    @(negedge wclk);
    start     = 1'b1;
    num_words = nw[15:0];
    mode      = md[1:0];
    seed      = sd[7:0];
    gap       = gp[3:0];
    push_cyc.delete();
    n_push = 0;
    l = (sd[7:0] == 8'd0) ? 32'd1 : 32'(sd[7:0]);
    for (int i = 0; i < nw; i++) begin
      if (md == 1) begin
        exp_q.push_back(l[7:0]);
        l = {l[30:0], ~(l[31] ^ l[21] ^ l[1] ^ l[0])};
      end else if (md == 2) begin
        exp_q.push_back(sd[7:0]);
      end else begin
        exp_q.push_back(8'(sd + i));
      end
    end
    @(negedge wclk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin
      @(negedge wclk);
      k++;
    end
    chk("done_seen", 32'(done), 1);
    done_cyc = cyc;
  endtask

  task automatic wait_push(input int n, input int budget);
    int k = 0;
    while (n_push < n && k < budget) begin
      @(negedge wclk);
      #3;
      k++;
    end
    chk("push_wait", 32'(n_push >= n), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge wclk);
    chk("rst_winc", 32'(winc), 0);
    chk("rst_wdata", 32'(wdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pushed", 32'(pushed_cnt), 0);
    chk("rst_stall", 32'(stall_cnt), 0);
    wrst_n = 1'b1;

    // increment with wrap, back-to-back
    go(4, 0, 'hFE, 0);
    wait_done(100);
    chk("inc_span", push_cyc[3] - push_cyc[0], 3);
    chk("inc_drain", done_cyc - push_cyc[3], 11);
    chk("inc_pushed", 32'(pushed_cnt), 4);
    chk("inc_q_empty", exp_q.size(), 0);
    chk("inc_busy", 32'(busy), 0);
    chk("done_wdata", 32'(wdata), 0);

    // constant with gap of 2 idle cycles
    go(3, 2, 'h5A, 2);
    wait_done(100);
    chk("gap_d1", push_cyc[1] - push_cyc[0], 3);
    chk("gap_d2", push_cyc[2] - push_cyc[1], 3);
    chk("const_pushed", 32'(pushed_cnt), 3);
    chk("const_q_empty", exp_q.size(), 0);

    // backpressure for 3 cycles after 2nd push
    go(5, 0, 0, 0);
    wait_push(2, 50);
    @(negedge wclk);
    wfull = 1'b1;
    chk("stall_busy", 32'(busy), 1);
    repeat (3) @(negedge wclk);
    wfull = 1'b0;
    wait_done(100);
    chk("bp_npush", n_push, 5);
    chk("bp_span", push_cyc[4] - push_cyc[0], 7);
    chk("bp_pushed", 32'(pushed_cnt), 5);
`ifdef FIFO_DRV_STALL_CNT_EN
    chk("bp_stall", 32'(stall_cnt), 3);
`else
    chk("bp_stall", 32'(stall_cnt), 0);
`endif
    chk("bp_q_empty", exp_q.size(), 0);

    // LFSR with zero seed
    go(2, 1, 0, 0);
    wait_done(100);
    chk("lfsr_pushed", 32'(pushed_cnt), 2);
    chk("lfsr_q_empty", exp_q.size(), 0);

    // reset mid-run
    go(6, 0, 'h10, 0);
    wait_push(2, 50);
    wrst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("arst_winc", 32'(winc), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_pushed", 32'(pushed_cnt), 0);
    chk("arst_wdata", 32'(wdata), 0);
    @(negedge wclk);
    wrst_n = 1'b1;
    n_push = 0;
    repeat (3) @(negedge wclk);
    chk("arst_idle_done", 32'(done), 0);
    chk("arst_nopush", n_push, 0);

    // zero-length run
    go(0, 0, 'h33, 0);
    chk("zero_done", 32'(done), 1);
    chk("zero_busy", 32'(busy), 0);
    repeat (3) @(negedge wclk);
    chk("zero_nopush", n_push, 0);
    chk("zero_pushed", 32'(pushed_cnt), 0);

    // clean run after reset, with start while busy
    go(4, 0, 'h40, 1);
    wait_push(1, 50);
    @(negedge wclk);
    start     = 1'b1;
    num_words = 16'd1;
    mode      = 2'b10;
    seed      = 8'h99;
    @(negedge wclk);
    start = 1'b0;
    wait_done(100);
    chk("busy_start_pushed", 32'(pushed_cnt), 4);
    chk("busy_start_npush", n_push, 4);
    chk("busy_start_q", exp_q.size(), 0);

    repeat (2) @(negedge wclk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
